// File: rtl/cordic_result_stage.sv
// Output stage of the CORDIC datapath: scales x/y by the gain K into cos/sin,
// forms tan with a restoring divider, and presents one saturated slice per request.
module cordic_result_stage #(
  parameter int W = 32,
  parameter int Q = 16,
  parameter int OUT_W = 16,
  parameter logic [W-1:0] K = W'(32'h00009B7B)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_ovf,
  output logic             out_dz
);

  localparam int SH = Q - OUT_W / 2;
  localparam int CW = $clog2(W);
  localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [2*W-1:0] K_EXT = {{W{K[W-1]}}, K};

  typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

  state_t                 state;
  logic [1:0]             sel_r;
  logic signed [W-1:0]    x_r, y_r, angle_r, cos_r, sin_r;
  logic                   mul_done, ovf_r;
  logic [W-1:0]           rem_r, lo_r, div_r;
  logic [W-2:0]           quot_r;
  logic                   neg_r, div_ovf_r;
  logic [CW-1:0]          cnt;

  logic signed [2*W-1:0]  prod_cos, prod_sin, shr_cos, shr_sin;
  logic signed [W-1:0]    cos_c, sin_c;
  logic                   cos_sat, sin_sat;
  logic [W-1:0]           abs_sin, abs_cos;
  logic [2*W-1:0]         dividend;
  logic [W:0]             tmp;
  logic                   ge;
  logic [W-1:0]           rem_next;
  logic [W-1:0]           quot_next;
  logic                   tan_ovf;
  logic signed [W-1:0]    tan_mag, tan_res;
  logic                   dz_c;
  logic signed [W-1:0]    r_sel, sh;
  logic                   r_ovf, fits;
  logic [OUT_W-1:0]       slice_data;
  logic                   slice_ovf;

  assign in_ready = (state == IDLE) && !rst;

  // Gain scaling: full-width signed product, arithmetic shift, then saturate to W bits.
  always_comb begin
    prod_cos = K_EXT * $signed({{W{x_r[W-1]}}, x_r});
    prod_sin = K_EXT * $signed({{W{y_r[W-1]}}, y_r});
    shr_cos  = prod_cos >>> Q;
    shr_sin  = prod_sin >>> Q;
    cos_sat  = !((shr_cos[2*W-1:W-1] == '0) || (shr_cos[2*W-1:W-1] == '1));
    sin_sat  = !((shr_sin[2*W-1:W-1] == '0) || (shr_sin[2*W-1:W-1] == '1));
    cos_c    = cos_sat ? (shr_cos[2*W-1] ? MIN_W : MAX_W) : shr_cos[W-1:0];
    sin_c    = sin_sat ? (shr_sin[2*W-1] ? MIN_W : MAX_W) : shr_sin[W-1:0];
    abs_sin  = sin_r[W-1] ? W'(-sin_r) : W'(sin_r);
    abs_cos  = cos_r[W-1] ? W'(-cos_r) : W'(cos_r);
    dividend = {{W{1'b0}}, abs_sin} << Q;
  end

  // One restoring-division step; the last step's quotient feeds the result directly.
  always_comb begin
    tmp       = {rem_r, lo_r[W-1]};
    ge        = (tmp >= {1'b0, div_r});
    rem_next  = ge ? (tmp[W-1:0] - div_r) : tmp[W-1:0];
    quot_next = {quot_r, ge};
    tan_ovf   = div_ovf_r | quot_next[W-1];
    tan_mag   = tan_ovf ? MAX_W : $signed(quot_next);
    tan_res   = neg_r ? -tan_mag : tan_mag;
  end

  always_comb begin
    dz_c  = (sel_r == 2'd3) && (cos_r == '0);
    r_sel = '0;
    r_ovf = 1'b0;
    if (state == DIV) begin
      r_sel = tan_res;
      r_ovf = tan_ovf;
    end else begin
      case (sel_r)
        2'd0:    r_sel = angle_r;
        2'd1:    r_sel = sin_r;
        2'd2:    r_sel = cos_r;
        default: r_sel = sin_r[W-1] ? -MAX_W : MAX_W;
      endcase
    end
    sh         = r_sel >>> SH;
    fits       = (sh[W-1:OUT_W-1] == '0) || (sh[W-1:OUT_W-1] == '1);
    slice_data = fits ? sh[OUT_W-1:0] : (sh[W-1] ? MIN_O : MAX_O);
    slice_ovf  = !fits;
  end

  // MUL takes two cycles: register the scaled values, then branch on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_r     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      angle_r   <= '0;
      cos_r     <= '0;
      sin_r     <= '0;
      mul_done  <= 1'b0;
      ovf_r     <= 1'b0;
      rem_r     <= '0;
      lo_r      <= '0;
      div_r     <= '0;
      quot_r    <= '0;
      neg_r     <= 1'b0;
      div_ovf_r <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
      out_ovf   <= 1'b0;
      out_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sel_r    <= sel;
            x_r      <= x;
            y_r      <= y;
            angle_r  <= angle;
            mul_done <= 1'b0;
            ovf_r    <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          if (!mul_done) begin
            cos_r    <= cos_c;
            sin_r    <= sin_c;
            ovf_r    <= cos_sat | sin_sat;
            mul_done <= 1'b1;
          end else if (sel_r != 2'd3 || dz_c) begin
            out_valid <= 1'b1;
            out_data  <= slice_data;
            out_mode  <= sel_r;
            out_ovf   <= ovf_r | r_ovf | slice_ovf;
            out_dz    <= dz_c;
            state     <= OUT;
          end else begin
            rem_r     <= dividend[2*W-1:W];
            lo_r      <= dividend[W-1:0];
            div_r     <= abs_cos;
            quot_r    <= '0;
            neg_r     <= sin_r[W-1] ^ cos_r[W-1];
            div_ovf_r <= (dividend[2*W-1:W] >= abs_cos);
            cnt       <= '0;
            state     <= DIV;
          end
        end
        DIV: begin
          rem_r  <= rem_next;
          lo_r   <= lo_r << 1;
          quot_r <= quot_next[W-2:0];
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            out_valid <= 1'b1;
            out_data  <= slice_data;
            out_mode  <= sel_r;
            out_ovf   <= ovf_r | r_ovf | slice_ovf;
            out_dz    <= 1'b0;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            out_dz    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
